// File: rtl/fc_sequencer.sv
// Control sequencer for one fully-connected layer: walks every output neuron,
// streams bias and input/weight chunks into the MAC ALU and hands each result out.
module fc_sequencer #(
    parameter int SIZE      = 16,
    parameter int PRECISION = 11,
    parameter int INPUT_SZ  = 4,
    parameter int LEN_W     = 10,
    parameter int ADDR_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [LEN_W-1:0]         in_len,
    input  logic [LEN_W-1:0]         out_len,
    input  logic [ADDR_W-1:0]        in_base,
    input  logic [ADDR_W-1:0]        w_base,
    input  logic [ADDR_W-1:0]        b_base,
    output logic                     busy,
    output logic                     done,
    output logic                     in_rd,
    output logic                     w_rd,
    output logic                     b_rd,
    output logic [ADDR_W-1:0]        in_addr,
    output logic [ADDR_W-1:0]        w_addr,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic [INPUT_SZ*SIZE-1:0] in_rdata,
    input  logic [INPUT_SZ*SIZE-1:0] w_rdata,
    input  logic [SIZE-1:0]          b_rdata,
    output logic [INPUT_SZ*SIZE-1:0] alu_inputs,
    output logic [INPUT_SZ*SIZE-1:0] alu_weights,
    output logic [SIZE-1:0]          alu_bias,
    output logic                     alu_clear,
    output logic                     alu_enable,
    input  logic [SIZE-1:0]          alu_value,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [SIZE-1:0]          out_data,
    output logic [LEN_W-1:0]         out_index
);

    if (PRECISION < 0 || PRECISION >= SIZE) begin : g_bad_precision
        $error("fc_sequencer: PRECISION must lie in [0, SIZE)");
    end

    typedef enum logic [2:0] {IDLE, BIAS, CLEAR, MAC, CAPTURE, OUT, DONE} state_t;

    localparam logic [LEN_W-1:0]  CHUNK    = LEN_W'(INPUT_SZ);
    localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state;
    logic [LEN_W-1:0]  n_len;
    logic [LEN_W-1:0]  m_len;
    logic [LEN_W-1:0]  j;
    logic [LEN_W-1:0]  rem;
    logic [ADDR_W-1:0] in_base_r;
    logic [ADDR_W-1:0] w_ptr;
    logic [LEN_W-1:0]  rem_next;
    logic [LEN_W-1:0]  j_next;

    // rem is the count of input elements not yet consumed at the current chunk,
    // so the last chunk is simply the one with rem <= INPUT_SZ (no division).
    assign rem_next = rem - CHUNK;
    assign j_next   = j + LEN_ONE;

    // Lanes past the end of the input vector are zeroed whatever memory returned.
    for (genvar i = 0; i < INPUT_SZ; i++) begin : g_lane
        logic lane_on;
        assign lane_on = alu_enable && (rem > LEN_W'(i));
        assign alu_inputs[i*SIZE +: SIZE]  = lane_on ? in_rdata[i*SIZE +: SIZE] : '0;
        assign alu_weights[i*SIZE +: SIZE] = lane_on ? w_rdata[i*SIZE +: SIZE]  : '0;
    end

    assign alu_bias = alu_clear ? b_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            in_rd      <= 1'b0;
            w_rd       <= 1'b0;
            b_rd       <= 1'b0;
            in_addr    <= '0;
            w_addr     <= '0;
            b_addr     <= '0;
            alu_clear  <= 1'b0;
            alu_enable <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_index  <= '0;
            n_len      <= '0;
            m_len      <= '0;
            j          <= '0;
            rem        <= '0;
            in_base_r  <= '0;
            w_ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        n_len     <= in_len;
                        m_len     <= out_len;
                        in_base_r <= in_base;
                        w_ptr     <= w_base;
                        j         <= '0;
                        if (in_len == '0 || out_len == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            b_rd   <= 1'b1;
                            b_addr <= b_base;
                            state  <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    b_rd      <= 1'b0;
                    alu_clear <= 1'b1;
                    in_rd     <= 1'b1;
                    w_rd      <= 1'b1;
                    in_addr   <= in_base_r;
                    w_addr    <= w_ptr;
                    w_ptr     <= w_ptr + ADDR_ONE;
                    rem       <= n_len;
                    state     <= CLEAR;
                end
                CLEAR: begin
                    alu_clear  <= 1'b0;
                    alu_enable <= 1'b1;
                    state      <= MAC;
                    if (rem > CHUNK) begin
                        in_addr <= in_addr + ADDR_ONE;
                        w_addr  <= w_ptr;
                        w_ptr   <= w_ptr + ADDR_ONE;
                    end else begin
                        in_rd <= 1'b0;
                        w_rd  <= 1'b0;
                    end
                end
                // Reads for chunk k+1 are issued while chunk k is being consumed.
                MAC: begin
                    if (rem > CHUNK) begin
                        rem <= rem_next;
                        if (rem_next > CHUNK) begin
                            in_addr <= in_addr + ADDR_ONE;
                            w_addr  <= w_ptr;
                            w_ptr   <= w_ptr + ADDR_ONE;
                        end else begin
                            in_rd <= 1'b0;
                            w_rd  <= 1'b0;
                        end
                    end else begin
                        alu_enable <= 1'b0;
                        in_rd      <= 1'b0;
                        w_rd       <= 1'b0;
                        state      <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    out_data  <= alu_value;
                    out_index <= j;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (j_next < m_len) begin
                            j      <= j_next;
                            b_rd   <= 1'b1;
                            b_addr <= b_addr + ADDR_ONE;
                            state  <= BIAS;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
